// File: rtl/range_pkg.sv
// range_pkg: shared definitions for the range sample datapath width adapters.
//   RANGE_W / RANGE_NCH : default chunk width and chunks per wide word
//   range_unpack_state_t: FSM state encoding for range_unpack
//   len_clamp()         : maps a raw chunk count onto 1..nch (0 or >nch -> nch)
package range_pkg;

  localparam int RANGE_W   = 4;
  localparam int RANGE_NCH = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } range_unpack_state_t;

  // A zero length means "full word"; oversize lengths saturate at nch.
  function automatic int len_clamp(input int len, input int nch);
    if (len <= 0 || len > nch) begin
      return nch;
    end
    return len;
  endfunction

endpackage

// File: rtl/range_unpack.sv
// range_unpack: wide-to-narrow width adapter.
// Takes one WI-bit word (NCH chunks of W bits) on a valid/ready handshake and
// replays its chunks least-significant first on a W-bit valid/ready stream,
// flagging the final chunk. A new word can be loaded on the same cycle the
// last chunk of the previous one is accepted, so streaming has no bubbles.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   in_vld   : wide word valid
//   in_rdy   : block accepts a word this cycle (comb from out_rdy)
//   in_data  : wide word, chunk k = in_data[k*W +: W]
//   in_len   : chunks to emit, 0 -> NCH, >NCH clamps to NCH
//   out_vld  : chunk valid
//   out_rdy  : consumer accepts the chunk
//   out_data : current chunk, 0 when out_vld is low
//   out_last : current chunk is the final one of the word
//   busy     : a word is held and not yet fully emitted
module range_unpack
  import range_pkg::*;
#(
  parameter  int W   = RANGE_W,
  parameter  int NCH = RANGE_NCH,
  localparam int WI  = W * NCH,
  localparam int LW  = $clog2(NCH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [WI-1:0] in_data,
  input  logic [LW-1:0] in_len,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  output logic          busy
);

  range_unpack_state_t state_reg, state_next;
  logic [WI-1:0] hold_reg, hold_next;
  logic [LW-1:0] rem_reg, rem_next;
  // Held low through reset and for the release edge so in_rdy stays 0 until
  // the first full cycle after reset deasserts.
  logic          ready_en_reg;

  logic          accept;
  logic          is_last;
  logic [LW-1:0] len_c;

  assign len_c    = LW'(len_clamp(int'(in_len), NCH));
  assign is_last  = (rem_reg == LW'(1));

  assign out_vld  = (state_reg == SEND);
  assign out_data = out_vld ? hold_reg[W-1:0] : '0;
  assign out_last = out_vld && is_last;
  assign busy     = (state_reg == SEND);

  // Only combinational path through the block: out_rdy -> in_rdy.
  assign in_rdy   = ready_en_reg &&
                    ((state_reg == IDLE) || (out_vld && out_rdy && out_last));
  assign accept   = in_vld && in_rdy;

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    rem_next   = rem_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          hold_next  = in_data;
          rem_next   = len_c;
          state_next = SEND;
        end
      end
      SEND: begin
        if (out_rdy) begin
          if (is_last) begin
            if (accept) begin
              hold_next = in_data;
              rem_next  = len_c;
            end else begin
              state_next = IDLE;
            end
          end else begin
            hold_next = hold_reg >> W;
            rem_next  = rem_reg - LW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      hold_reg     <= '0;
      rem_reg      <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_reg     <= hold_next;
      rem_reg      <= rem_next;
      ready_en_reg <= 1'b1;
    end
  end

endmodule
